// File: rtl/pipemips_pkg.sv
// Shared types and default constants for the PipelineMIPS fetch front end.
package pipemips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          INC_DEF       = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect priority mux (exception > branch > jump) with word alignment and
// detection of a misaligned raw target.
module pc_next_sel
  import pipemips_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic              exc,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_branch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    raw_target = '0;
    if (exc) begin
      raw_target = EXC_VEC;
    end else if (pc_src) begin
      raw_target = pc_branch;
    end else if (jump) begin
      raw_target = jump_target;
    end
    redirect   = exc | pc_src | jump;
    target     = {raw_target[ADDR_W-1:2], 2'b00};
    misaligned = redirect & (raw_target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch request unit: req/ready handshake,
// redirects with stale-fetch squashing, and a one-entry skid for stalled results.
module pc_fetch_unit
  import pipemips_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
  parameter int                INC       = INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] PCBranch,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pcaddr,
  output logic [ADDR_W-1:0] pcplus4addr,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              misalign_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] res_pc_q, res_pc_d;
  logic              res_valid_q, res_valid_d;
  logic              skid_q, skid_d;
  logic              outstanding_q, outstanding_d;
  logic              misalign_q, misalign_d;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic [ADDR_W-1:0] pc_plus;

  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .EXC_VEC(EXC_VEC)
  ) u_next_sel (
    .exc        (exc),
    .pc_src     (PCSrc),
    .pc_branch  (PCBranch),
    .jump       (jump),
    .jump_target(jump_target),
    .redirect   (redirect),
    .target     (target),
    .misaligned (misaligned)
  );

  assign pc_plus = pc_q + ADDR_W'(INC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    res_pc_d    = res_pc_q;
    res_valid_d = res_valid_q;
    skid_d      = skid_q;
    misalign_d  = 1'b0;
    imem_req    = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        // A skidded result is delivered on its own cycle, so no new request then.
        imem_req = outstanding_q | (!stall & !skid_q);
        if (res_valid_q && !stall) begin
          res_valid_d = 1'b0;
          skid_d      = 1'b0;
        end
        if (redirect) begin
          misalign_d  = misaligned;
          res_valid_d = 1'b0;
          skid_d      = 1'b0;
          // A raised but unaccepted request must hold its address, so park the target.
          if (imem_req && !imem_ready) begin
            pend_d  = target;
            state_d = DRAIN;
          end else begin
            pc_d = target;
          end
        end else if (imem_req && imem_ready) begin
          pc_d        = pc_plus;
          res_pc_d    = pc_q;
          res_valid_d = 1'b1;
          skid_d      = stall;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (redirect) begin
          misalign_d = misaligned;
          pend_d     = target;
        end
        if (imem_ready) begin
          pc_d    = redirect ? target : pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    outstanding_d = imem_req & !imem_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      pend_q        <= '0;
      res_pc_q      <= '0;
      res_valid_q   <= 1'b0;
      skid_q        <= 1'b0;
      outstanding_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      res_pc_q      <= res_pc_d;
      res_valid_q   <= res_valid_d;
      skid_q        <= skid_d;
      outstanding_q <= outstanding_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pcaddr       = pc_q;
  assign pcplus4addr  = pc_plus;
  assign fetch_valid  = res_valid_q & !stall;
  assign fetch_pc     = res_pc_q;
  assign misalign_err = misalign_q;

endmodule
